// File: rtl/async_event_sync.sv
// Multi-channel asynchronous level synchroniser with glitch filter, edge-event
// strobe, and per-channel pending / sticky overflow status.
module async_event_sync #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 3,
    parameter int FILTER_CYCLES = 4,
    parameter int EDGE_MODE     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] async_in,
    input  logic [CHANNELS-1:0] ack,
    input  logic                clr_overflow,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] pulse_out,
    output logic [CHANNELS-1:0] pending,
    output logic [CHANNELS-1:0] overflow
);
    localparam int               CNT_W    = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [CHANNELS-1:0] sync_ff [SYNC_STAGES];
    logic [CHANNELS-1:0] sync_q;
    logic [CNT_W-1:0]    cnt_q   [CHANNELS];
    logic [CNT_W-1:0]    cnt_d   [CHANNELS];
    logic [CHANNELS-1:0] level_d;
    logic [CHANNELS-1:0] changed;
    logic [CHANNELS-1:0] event_d;
    logic [CHANNELS-1:0] pending_d;
    logic [CHANNELS-1:0] overflow_d;

    assign sync_q = sync_ff[SYNC_STAGES-1];

    // NOTE: the synchroniser chain is reset like any other state so that a
    // reset mid-transition cannot leak a stale level into the filter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_ff[i] <= '0;
        end else begin
            sync_ff[0] <= async_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_ff[i] <= sync_ff[i-1];
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        level_d = level_out;
        for (int c = 0; c < CHANNELS; c++) begin
            cnt_d[c] = '0;
            if (sync_q[c] != level_out[c]) begin
                if (cnt_q[c] == CNT_LAST) level_d[c] = sync_q[c];
                else                      cnt_d[c]   = cnt_q[c] + 1'b1;
            end
        end
    end

    assign changed = level_d ^ level_out;

    always_comb begin
        event_d = '0;
        case (EDGE_MODE)
            0:       event_d = changed & level_d;
            1:       event_d = changed & ~level_d;
            default: event_d = changed;
        endcase
    end

    // A new event dominates both ack (pending) and clr_overflow (overflow).
    assign pending_d  = event_d | (pending & ~ack);
    assign overflow_d = (event_d & pending & ~ack)
                      | (overflow & ~{CHANNELS{clr_overflow}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
            level_out <= '0;
            pulse_out <= '0;
            pending   <= '0;
            overflow  <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= cnt_d[c];
            level_out <= level_d;
            pulse_out <= event_d;
            pending   <= pending_d;
            overflow  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_async_event_sync.sv
// Randomised and directed bench for async_event_sync; three instances cover
// EDGE_MODE 2, 0 and 1 against a run-length reference model.
module tb_async_event_sync;
    localparam int CH = 4;
    localparam int S  = 3;
    localparam int F  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] async_in;
    logic [CH-1:0] ack;
    logic          clr_overflow;
    logic [CH-1:0] lvl [3];
    logic [CH-1:0] pls [3];
    logic [CH-1:0] pnd [3];
    logic [CH-1:0] ovf [3];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Index 0: both edges, index 1: rising only, index 2: falling only.
    async_event_sync #(.CHANNELS(CH), .SYNC_STAGES(S), .FILTER_CYCLES(F), .EDGE_MODE(2)) u_both (
        .clk(clk), .rst_n(rst_n), .async_in(async_in), .ack(ack), .clr_overflow(clr_overflow),
        .level_out(lvl[0]), .pulse_out(pls[0]), .pending(pnd[0]), .overflow(ovf[0]));
    async_event_sync #(.CHANNELS(CH), .SYNC_STAGES(S), .FILTER_CYCLES(F), .EDGE_MODE(0)) u_rise (
        .clk(clk), .rst_n(rst_n), .async_in(async_in), .ack(ack), .clr_overflow(clr_overflow),
        .level_out(lvl[1]), .pulse_out(pls[1]), .pending(pnd[1]), .overflow(ovf[1]));
    async_event_sync #(.CHANNELS(CH), .SYNC_STAGES(S), .FILTER_CYCLES(F), .EDGE_MODE(1)) u_fall (
        .clk(clk), .rst_n(rst_n), .async_in(async_in), .ack(ack), .clr_overflow(clr_overflow),
        .level_out(lvl[2]), .pulse_out(pls[2]), .pending(pnd[2]), .overflow(ovf[2]));

    // Reference model: level follows the input seen S edges late once it has
    // differed from the current level for F consecutive edges.
    logic [CH-1:0] hist [$];
    logic [CH-1:0] m_lvl [3];
    logic [CH-1:0] m_pls [3];
    logic [CH-1:0] m_pnd [3];
    logic [CH-1:0] m_ovf [3];
    int            m_run [3][CH];

    function automatic int mode_of(input int m);
        return (m == 0) ? 2 : (m == 1) ? 0 : 1;
    endfunction

    function automatic logic [4*CH-1:0] dut_state(input int m);
        return {ovf[m], pnd[m], pls[m], lvl[m]};
    endfunction

    function automatic logic [4*CH-1:0] model_state(input int m);
        return {m_ovf[m], m_pnd[m], m_pls[m], m_lvl[m]};
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int m = 0; m < 3; m++) begin
            m_lvl[m] = '0; m_pls[m] = '0; m_pnd[m] = '0; m_ovf[m] = '0;
            for (int c = 0; c < CH; c++) m_run[m][c] = 0;
        end
    endtask

    task automatic model_edge(input logic [CH-1:0] in_v, input logic [CH-1:0] ack_v,
                              input logic clr_v);
        logic [CH-1:0] seen;
        logic          ev;
        hist.push_back(in_v);
        if (hist.size() > S + 1) void'(hist.pop_front());
        seen = (hist.size() == S + 1) ? hist[0] : '0;
        for (int m = 0; m < 3; m++) begin
            for (int c = 0; c < CH; c++) begin
                ev = 1'b0;
                if (seen[c] != m_lvl[m][c]) begin
                    m_run[m][c]++;
                    if (m_run[m][c] == F) begin
                        m_lvl[m][c] = seen[c];
                        m_run[m][c] = 0;
                        ev = (mode_of(m) == 2) || (mode_of(m) == 0 && seen[c])
                          || (mode_of(m) == 1 && !seen[c]);
                    end
                end else begin
                    m_run[m][c] = 0;
                end
                m_pls[m][c] = ev;
                if (ev && m_pnd[m][c] && !ack_v[c]) m_ovf[m][c] = 1'b1;
                else if (clr_v)                     m_ovf[m][c] = 1'b0;
                if (ev)            m_pnd[m][c] = 1'b1;
                else if (ack_v[c]) m_pnd[m][c] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge(async_in, ack, clr_overflow);
        #1;
    endtask

    task automatic settle(input int n);
        async_in = '0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ack = '0; clr_overflow = 1'b0;
        for (int i = 0; i < 4; i++) begin
            async_in = CH'($urandom);
            tick();
            for (int m = 0; m < 3; m++) begin
                vectors++;
                if (dut_state(m) !== '0) begin
                    miscompares++;
                    $display("FAIL reset_hold dut%0d got %h required 0", m, dut_state(m));
                end
            end
        end
        async_in = 4'b0001;
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            for (int m = 0; m < 3; m++) begin
                vectors++;
                if (dut_state(m) !== model_state(m)) begin
                    miscompares++;
                    $display("FAIL reset_release e%0d dut%0d got %h required %h", e, m, dut_state(m), model_state(m));
                end
            end
            if (e == 7) begin
                vectors++;
                if ({lvl[0][0], pls[0][0], pnd[2][0]} !== 3'b110) begin
                    miscompares++;
                    $display("FAIL reset_edge7 got lvl/pls/pnd_fall=%b required 110", {lvl[0][0], pls[0][0], pnd[2][0]});
                end
            end
            if (e == 8) begin
                vectors++;
                if (pls[0][0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_pulse_width got %b required 0", pls[0][0]);
                end
            end
        end
    endtask

    task automatic test_latency();
        async_in = 4'b0011;
        for (int e = 1; e <= 9; e++) begin
            if (e == 9) ack = 4'b0010;
            tick();
            ack = '0;
            for (int m = 0; m < 3; m++) begin
                vectors++;
                if (dut_state(m) !== model_state(m)) begin
                    miscompares++;
                    $display("FAIL latency e%0d dut%0d got %h required %h", e, m, dut_state(m), model_state(m));
                end
            end
            if (e == 6 || e == 7 || e == 9) begin
                vectors++;
                if ({lvl[0][1], pls[0][1], pnd[0][1]} !== ((e == 6) ? 3'b000 : (e == 7) ? 3'b111 : 3'b100)) begin
                    miscompares++;
                    $display("FAIL latency_ch1 e%0d got lvl/pls/pnd=%b", e, {lvl[0][1], pls[0][1], pnd[0][1]});
                end
            end
        end
    endtask

    task automatic test_glitch();
        for (int e = 1; e <= 26; e++) begin
            async_in[2] = (e <= 3) || (e >= 15 && e <= 18);
            tick();
            for (int m = 0; m < 3; m++) begin
                vectors++;
                if (dut_state(m) !== model_state(m)) begin
                    miscompares++;
                    $display("FAIL glitch e%0d dut%0d got %h required %h", e, m, dut_state(m), model_state(m));
                end
            end
            if (e <= 14) begin
                vectors++;
                if ({lvl[0][2], pls[0][2], pnd[0][2]} !== 3'b000) begin
                    miscompares++;
                    $display("FAIL glitch_reject e%0d got lvl/pls/pnd=%b required 000", e, {lvl[0][2], pls[0][2], pnd[0][2]});
                end
            end
            if (e == 21 || e == 24 || e == 25) begin
                vectors++;
                if ({lvl[0][2], pls[0][2]} !== ((e == 21) ? 2'b11 : (e == 24) ? 2'b10 : 2'b01)) begin
                    miscompares++;
                    $display("FAIL glitch_accept e%0d got lvl/pls=%b", e, {lvl[0][2], pls[0][2]});
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [3:0] ph_v, ph_ack, ph_clr, ph_ovf;
        ph_v = 4'b0101; ph_ack = 4'b0100; ph_clr = 4'b1000; ph_ovf = 4'b1110;
        for (int p = 0; p < 4; p++) begin
            async_in[3] = ph_v[p];
            for (int e = 1; e <= 7; e++) begin
                if (e == 7) begin ack[3] = ph_ack[p]; clr_overflow = ph_clr[p]; end
                tick();
                ack = '0; clr_overflow = 1'b0;
                for (int m = 0; m < 3; m++) begin
                    vectors++;
                    if (dut_state(m) !== model_state(m)) begin
                        miscompares++;
                        $display("FAIL overflow p%0d e%0d dut%0d got %h required %h", p, e, m, dut_state(m), model_state(m));
                    end
                end
            end
            vectors++;
            if ({pls[0][3], pnd[0][3], ovf[0][3]} !== {2'b11, ph_ovf[p]}) begin
                miscompares++;
                $display("FAIL overflow_ch3 p%0d got pls/pnd/ovf=%b required %b", p, {pls[0][3], pnd[0][3], ovf[0][3]}, {2'b11, ph_ovf[p]});
            end
            if (p == 2) begin
                clr_overflow = 1'b1;
                tick();
                clr_overflow = 1'b0;
                vectors++;
                if ({pnd[0][3], ovf[0][3]} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL overflow_clear got pnd/ovf=%b required 10", {pnd[0][3], ovf[0][3]});
                end
            end
        end
    endtask

    task automatic test_edge_mode();
        int np [3];
        int nr [3];
        settle(12);
        for (int m = 0; m < 3; m++) begin np[m] = 0; nr[m] = 0; end
        for (int e = 1; e <= 20; e++) begin
            async_in[0] = (e <= 10);
            tick();
            for (int m = 0; m < 3; m++) begin
                np[m] += int'(pls[m][0]);
                if (e <= 10) nr[m] += int'(pls[m][0]);
                vectors++;
                if (dut_state(m) !== model_state(m)) begin
                    miscompares++;
                    $display("FAIL edge_mode e%0d dut%0d got %h required %h", e, m, dut_state(m), model_state(m));
                end
                if (e == 10 || e == 20) begin
                    vectors++;
                    if (lvl[m][0] !== (e == 10)) begin
                        miscompares++;
                        $display("FAIL edge_mode_level e%0d dut%0d got %b", e, m, lvl[m][0]);
                    end
                end
            end
        end
        for (int m = 0; m < 3; m++) begin
            vectors++;
            if (np[m] != ((m == 0) ? 2 : 1) || nr[m] != ((m == 2) ? 0 : 1)) begin
                miscompares++;
                $display("FAIL edge_mode_count dut%0d got total=%0d rising=%0d", m, np[m], nr[m]);
            end
        end
    endtask

    task automatic test_multi();
        logic [CH-1:0] ack_seq [3];
        logic [CH-1:0] pnd_seq [3];
        settle(12);
        ack = '1; tick(); ack = '0;
        async_in = '1;
        ack_seq[0] = 4'b0000; ack_seq[1] = 4'b0010; ack_seq[2] = 4'b1000;
        pnd_seq[0] = 4'b1111; pnd_seq[1] = 4'b1101; pnd_seq[2] = 4'b0101;
        for (int e = 1; e <= 9; e++) begin
            if (e >= 8) ack = ack_seq[e-7];
            tick();
            ack = '0;
            for (int m = 0; m < 3; m++) begin
                vectors++;
                if (dut_state(m) !== model_state(m)) begin
                    miscompares++;
                    $display("FAIL multi e%0d dut%0d got %h required %h", e, m, dut_state(m), model_state(m));
                end
            end
            if (e >= 7) begin
                vectors++;
                if ({pls[0], pnd[0]} !== {((e == 7) ? 4'b1111 : 4'b0000), pnd_seq[e-7]}) begin
                    miscompares++;
                    $display("FAIL multi_ch e%0d got pls=%b pnd=%b required pnd=%b", e, pls[0], pnd[0], pnd_seq[e-7]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        async_in = 4'b0000;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int m = 0; m < 3; m++) begin
            vectors++;
            if (dut_state(m) !== '0) begin
                miscompares++;
                $display("FAIL mid_reset_async dut%0d got %h required 0", m, dut_state(m));
            end
        end
        repeat (3) begin async_in = CH'($urandom); tick(); end
        async_in = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            for (int m = 0; m < 3; m++) begin
                vectors++;
                if (dut_state(m) !== model_state(m) || pls[m] !== '0) begin
                    miscompares++;
                    $display("FAIL mid_reset e%0d dut%0d got %h required %h", e, m, dut_state(m), model_state(m));
                end
            end
        end
    endtask

    task automatic test_random();
        int hold [CH];
        for (int c = 0; c < CH; c++) hold[c] = 0;
        for (int t = 0; t < 600; t++) begin
            for (int c = 0; c < CH; c++) begin
                if (hold[c] == 0) begin
                    async_in[c] = ~async_in[c];
                    hold[c] = $urandom_range(1, 2 * F + 2);
                end else begin
                    hold[c]--;
                end
            end
            ack          = CH'($urandom) & CH'($urandom);
            clr_overflow = ($urandom_range(0, 7) == 0);
            tick();
            for (int m = 0; m < 3; m++) begin
                vectors++;
                if (dut_state(m) !== model_state(m)) begin
                    miscompares++;
                    $display("FAIL random t%0d dut%0d got %h required %h", t, m, dut_state(m), model_state(m));
                end
            end
        end
        ack = '0; clr_overflow = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; async_in = '0; ack = '0; clr_overflow = 1'b0;
        model_reset();
        #2;
        test_reset();
        test_latency();
        test_glitch();
        test_overflow();
        test_edge_mode();
        test_multi();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got no completion required finish");
        $fatal(1, "timeout");
    end

endmodule
